signed_prod_acc: RTL

- Downstream consumer of the signed 8x8 multiplier stage; takes its 16-bit signed product stream with valid.
- Accumulates ACC_LEN consecutive valid products into a full-precision signed accumulator.
- Scales the sum by an arithmetic right shift with round-half-up, saturates it to DOUT_W, and presents the result on a valid/ready output handshake.
- Forms the dot-product / moving-block-sum stage of the MAC datapath.

---
 rtl/signed_prod_acc.sv | 131 +++++++++++++
 1 files changed

// File: rtl/signed_prod_acc.sv
// Purpose: accumulate ACC_LEN signed products, scale by >>>SHIFT with round-half-up, saturate to DOUT_W.
// Latency: dout_vld rises one cycle after the last sample of a block is accepted.
// Backpressure: din_rdy drops while a result is pending; dout holds until dout_vld & dout_rdy.
module signed_prod_acc #(
  parameter int DIN_W   = 16,
  parameter int ACC_LEN = 8,
  parameter int SHIFT   = 2,
  parameter int DOUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic signed [DIN_W-1:0]  din,
  input  logic                     din_vld,
  output logic                     din_rdy,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  output logic                     sat_flag
);

  localparam int CNT_W = $clog2(ACC_LEN);
  // Accumulator wide enough that ACC_LEN full-scale products cannot overflow.
  localparam int AW    = DIN_W + CNT_W;
  // One extra bit so adding the rounding half cannot wrap.
  localparam int RW    = AW + 1;
  // Compare width covers both the rounded sum and the output range plus a sign bit.
  localparam int CW    = ((RW > DOUT_W) ? RW : DOUT_W) + 1;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);
  localparam logic signed [CW-1:0] MAXV = {{(CW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {{(CW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t                    state;
  logic signed [AW-1:0]      acc;
  logic signed [AW-1:0]      sum;
  logic [CNT_W-1:0]          cnt;
  logic signed [RW-1:0]      sum_ext;
  logic signed [RW-1:0]      rnd_sum;
  logic signed [CW-1:0]      scaled;
  logic signed [DOUT_W-1:0]  clamped;
  logic                      sat_now;
  logic                      accept;

  // Ready depends on state only, so there is no combinational path from din_vld or dout_rdy.
  assign din_rdy = (state == ACC);
  assign accept  = din_vld & din_rdy;

  // Full-precision running sum including the sample on the input this cycle.
  assign sum     = acc + AW'(din);
  assign sum_ext = RW'(sum);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
      // floor(x + 0.5): add half an LSB of the result, then arithmetic shift.
      assign rnd_sum = (sum_ext + HALF) >>> SHIFT;
    end else begin : g_no_round
      assign rnd_sum = sum_ext;
    end
  endgenerate

  assign scaled = CW'(rnd_sum);

  // Clamp the scaled sum into the signed output range and flag when it had to.
  always_comb begin
    sat_now = 1'b0;
    clamped = DOUT_W'(scaled);
    if (scaled > MAXV) begin
      clamped = MAXV[DOUT_W-1:0];
      sat_now = 1'b1;
    end else if (scaled < MINV) begin
      clamped = MINV[DOUT_W-1:0];
      sat_now = 1'b1;
    end
  end

  // Block FSM: accumulate in ACC, present the result in OUT until handshake; clr wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      sat_flag <= 1'b0;
    end else if (clr) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      dout_vld <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (cnt == LAST) begin
              dout     <= clamped;
              dout_vld <= 1'b1;
              if (sat_now) begin
                sat_flag <= 1'b1;
              end
              acc      <= '0;
              cnt      <= '0;
              state    <= OUT;
            end else begin
              acc <= sum;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        OUT: begin
          if (dout_rdy) begin
            dout_vld <= 1'b0;
            state    <= ACC;
          end
        end
        default: begin
          state    <= ACC;
          dout_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
